instr_data_memory: RTL and testbench
====================================

INSTR_DATA_MEMORY -- requirements
Module: instr_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 10, word-address bits (depth 2^ADDR_W words).
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive cycles a pending fetch is denied.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port FetchReq  input  1  instruction fetch request.
REQ-007 SHALL have port ReadPC  input  32  fetch byte address.
REQ-008 SHALL have port FetchGnt  output  1  fetch accepted this cycle.
REQ-009 SHALL have port Instruction  output  DATA_W  fetched word.
REQ-010 SHALL have port InstrValid  output  1  Instruction valid pulse.
REQ-011 SHALL have port Op2En  input  1  data access request.
REQ-012 SHALL have port Op2RW  input  1  1 = write, 0 = read.
REQ-013 SHALL have port ReadWriteAddr  input  32  data byte address.
REQ-014 SHALL have port DataWrite  input  DATA_W  store data.
REQ-015 SHALL have port ByteEn  input  DATA_W/8  store byte-lane enables.
REQ-016 SHALL have port Op2Gnt  output  1  data access accepted this cycle.
REQ-017 SHALL have port DataRead  output  DATA_W  load data.
REQ-018 SHALL have port DataValid  output  1  DataRead valid pulse.
REQ-019 SHALL have ports FetchFault, DataFault  output  1  misalignment pulses.

Function
REQ-020 SHALL hold one single-ported array of 2^ADDR_W x DATA_W shared by both ports.
REQ-021 SHALL index with address bits [ADDR_W+L-1:L], L = log2(DATA_W/8); higher bits ignored (wrap).
REQ-022 SHALL grant at most one port per cycle; FetchGnt/Op2Gnt combinational from requests and state.
REQ-023 SHALL give data port priority, except when starvation counter equals STARVE_MAX: fetch granted, data denied that cycle.
REQ-024 SHALL increment starvation counter each cycle FetchReq is high and denied; clear it on fetch grant or FetchReq low.
REQ-025 SHALL grant a request with no competing request in the same cycle.
REQ-026 SHALL require requester to hold request and operands stable until granted.
REQ-027 SHALL return read data (fetch or data read) registered, one cycle after grant, with a one-cycle Valid pulse.
REQ-028 SHALL hold Instruction and DataRead at last returned value between pulses.
REQ-029 SHALL on granted write update only lanes with ByteEn=1 at the grant edge; no DataValid pulse.
REQ-030 SHALL return newly written data for a read of the same word granted the next cycle.
REQ-031 SHALL treat granted write with ByteEn all-zero as no-op.

Reset
REQ-032 SHALL on reset clear Instruction, DataRead, InstrValid, DataValid, FetchFault, DataFault, starvation counter to 0.
REQ-033 SHALL drop any read pending return when reset asserts mid-operation; array contents unaffected.
REQ-034 SHALL issue no grants while reset is high.

Configuration
REQ-035 SHALL with MISALIGN_CHECK_EN defined flag any granted access with address bits [L-1:0] nonzero: fault pulse one cycle after grant, no Valid, no write.
REQ-036 SHALL without MISALIGN_CHECK_EN ignore address bits [L-1:0] and tie FetchFault, DataFault to 0.

Structure
REQ-037 SHALL take default parameter values, RW encoding constants and lane-count function from package mem_pkg.
REQ-038 SHALL place grant logic and starvation counter in sub-module mem_arbiter.

Verification (DATA_W=32, ADDR_W=10, STARVE_MAX=4)
REQ-039 SHALL check: write 0xDEADBEEF to 0x10 ByteEn 1111, read 0x10 next cycle -> DataValid one cycle later, DataRead 0xDEADBEEF.
REQ-040 SHALL check: over 0xDEADBEEF write 0x000000AA ByteEn 0001, read -> 0xDEADBEAA.
REQ-041 SHALL check: FetchReq and Op2En held high 6 cycles -> Op2Gnt cycles 1-4, FetchGnt cycle 5, Op2Gnt cycle 6.
REQ-042 SHALL check: fetch 0x1000 after writing 0x00000001 at 0x0 -> Instruction 0x00000001 (wrap).
REQ-043 SHALL check: fetch ReadPC 0x2 -> with macro FetchFault pulse, no InstrValid; without, Instruction = word 0.
REQ-044 SHALL check: reset asserted the cycle after a read grant -> no DataValid, DataRead 0, array contents unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults, access encodings and lane helpers for the unified instruction/data memory.
package mem_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 10;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits below the word index.
  function automatic int lane_bits(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 0;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-grant arbiter: data port wins unless a pending fetch has been denied STARVE_MAX cycles.
// Grants are combinational from requests and the starvation counter; no grants during reset.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_fetch_req,
  input  logic i_data_req,
  output logic o_fetch_gnt,
  output logic o_data_gnt
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved   = (r_starve_cnt == STARVE_LIMIT);
  assign o_data_gnt  = !reset && i_data_req && !(i_fetch_req && w_starved);
  assign o_fetch_gnt = !reset && i_fetch_req && (!i_data_req || w_starved);

  // The counter never passes the limit: at the limit the fetch is granted and it clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!i_fetch_req || o_fetch_gnt) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_data_memory.sv
// Single-ported word array shared by a fetch port and a byte-enabled load/store port; reads return one cycle after grant.
// Optional MISALIGN_CHECK_EN turns accesses with nonzero byte-offset bits into one-cycle fault pulses.
module instr_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FetchReq,
  input  logic [31:0]         ReadPC,
  output logic                FetchGnt,
  output logic [DATA_W-1:0]   Instruction,
  output logic                InstrValid,
  input  logic                Op2En,
  input  logic                Op2RW,
  input  logic [31:0]         ReadWriteAddr,
  input  logic [DATA_W-1:0]   DataWrite,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic                Op2Gnt,
  output logic [DATA_W-1:0]   DataRead,
  output logic                DataValid,
  output logic                FetchFault,
  output logic                DataFault
);

  localparam int LANES = lane_count(DATA_W);
  localparam int L     = lane_bits(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [DATA_W-1:0] r_instr;
  logic              r_instr_vld;
  logic [DATA_W-1:0] r_data;
  logic              r_data_vld;

  logic [ADDR_W-1:0] w_fetch_idx;
  logic [ADDR_W-1:0] w_data_idx;
  logic              w_fetch_gnt;
  logic              w_data_gnt;
  logic              w_fetch_mis;
  logic              w_data_mis;
  logic              w_fetch_rd;
  logic              w_data_rd;
  logic              w_data_wr;
  logic              w_unused_addr;

  // Upper address bits wrap; only the word index is decoded.
  assign w_fetch_idx   = ReadPC[ADDR_W+L-1:L];
  assign w_data_idx    = ReadWriteAddr[ADDR_W+L-1:L];
  assign w_unused_addr = ^{ReadPC, ReadWriteAddr};

  mem_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .i_fetch_req(FetchReq),
    .i_data_req (Op2En),
    .o_fetch_gnt(w_fetch_gnt),
    .o_data_gnt (w_data_gnt)
  );

  assign FetchGnt = w_fetch_gnt;
  assign Op2Gnt   = w_data_gnt;

`ifdef MISALIGN_CHECK_EN
  localparam logic [31:0] OFFSET_MASK = 32'(LANES - 1);

  logic r_fetch_fault;
  logic r_data_fault;

  assign w_fetch_mis = |(ReadPC & OFFSET_MASK);
  assign w_data_mis  = |(ReadWriteAddr & OFFSET_MASK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_fault <= 1'b0;
      r_data_fault  <= 1'b0;
    end else begin
      r_fetch_fault <= w_fetch_gnt && w_fetch_mis;
      r_data_fault  <= w_data_gnt && w_data_mis;
    end
  end

  assign FetchFault = r_fetch_fault;
  assign DataFault  = r_data_fault;
`else
  assign w_fetch_mis = 1'b0;
  assign w_data_mis  = 1'b0;
  assign FetchFault  = 1'b0;
  assign DataFault   = 1'b0;
`endif

  assign w_fetch_rd = w_fetch_gnt && !w_fetch_mis;
  assign w_data_rd  = w_data_gnt && !w_data_mis && (Op2RW == OP_READ);
  assign w_data_wr  = w_data_gnt && !w_data_mis && (Op2RW == OP_WRITE);

  // Array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_data_wr) begin
      for (int b = 0; b < LANES; b++) begin
        if (ByteEn[b]) begin
          r_mem[w_data_idx][8*b +: 8] <= DataWrite[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr     <= '0;
      r_instr_vld <= 1'b0;
      r_data      <= '0;
      r_data_vld  <= 1'b0;
    end else begin
      r_instr_vld <= w_fetch_rd;
      r_data_vld  <= w_data_rd;
      if (w_fetch_rd) begin
        r_instr <= r_mem[w_fetch_idx];
      end
      if (w_data_rd) begin
        r_data <= r_mem[w_data_idx];
      end
    end
  end

  assign Instruction = r_instr;
  assign InstrValid  = r_instr_vld;
  assign DataRead    = r_data;
  assign DataValid   = r_data_vld;

endmodule

// File: tb/tb_instr_data_memory.sv
// Scoreboard bench for instr_data_memory: read expectations are queued at grant and retired on Valid pulses.
module tb_instr_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        FetchReq = 1'b0;
  logic [31:0] ReadPC = '0;
  logic        FetchGnt;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Op2En = 1'b0;
  logic        Op2RW = 1'b0;
  logic [31:0] ReadWriteAddr = '0;
  logic [31:0] DataWrite = '0;
  logic [3:0]  ByteEn = '0;
  logic        Op2Gnt;
  logic [31:0] DataRead;
  logic        DataValid;
  logic        FetchFault;
  logic        DataFault;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] model_mem[int];

  instr_data_memory #(
    .DATA_W(32),
    .ADDR_W(10),
    .STARVE_MAX(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .FetchReq     (FetchReq),
    .ReadPC       (ReadPC),
    .FetchGnt     (FetchGnt),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .Op2En        (Op2En),
    .Op2RW        (Op2RW),
    .ReadWriteAddr(ReadWriteAddr),
    .DataWrite    (DataWrite),
    .ByteEn       (ByteEn),
    .Op2Gnt       (Op2Gnt),
    .DataRead     (DataRead),
    .DataValid    (DataValid),
    .FetchFault   (FetchFault),
    .DataFault    (DataFault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  // Retire queued read expectations on every Valid pulse.
  always @(negedge clk) begin
    if (DataValid) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL data_unexpected: DataValid=1 DataRead=%h, required no pulse", DataRead);
      end else begin
        logic [31:0] e;
        e = exp_data_q.pop_front();
        if (DataRead !== e) begin
          errors++;
          $display("FAIL data_read: got %h required %h", DataRead, e);
        end
      end
    end
    if (InstrValid) begin
      checks++;
      if (exp_instr_q.size() == 0) begin
        errors++;
        $display("FAIL instr_unexpected: InstrValid=1 Instruction=%h, required no pulse", Instruction);
      end else begin
        logic [31:0] e;
        e = exp_instr_q.pop_front();
        if (Instruction !== e) begin
          errors++;
          $display("FAIL instruction: got %h required %h", Instruction, e);
        end
      end
    end
  end

  task automatic data_op(input logic rw, input logic [31:0] addr, input logic [31:0] wdat, input logic [3:0] be);
    int n;
    logic [31:0] w;
    n = 0;
    Op2En = 1'b1; Op2RW = rw; ReadWriteAddr = addr; DataWrite = wdat; ByteEn = be;
    @(negedge clk);
    while (!Op2Gnt && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!Op2Gnt) begin
      errors++;
      $display("FAIL data_grant_timeout: Op2Gnt=%b required 1 (addr %h)", Op2Gnt, addr);
    end else if (rw) begin
      w = model_mem.exists(widx(addr)) ? model_mem[widx(addr)] : 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdat[8*b +: 8];
      model_mem[widx(addr)] = w;
    end else begin
      exp_data_q.push_back(model_mem[widx(addr)]);
    end
    @(posedge clk); #1;
    Op2En = 1'b0;
  endtask

  task automatic fetch_op(input logic [31:0] addr, input bit push_exp);
    int n;
    n = 0;
    FetchReq = 1'b1; ReadPC = addr;
    @(negedge clk);
    while (!FetchGnt && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!FetchGnt) begin
      errors++;
      $display("FAIL fetch_grant_timeout: FetchGnt=%b required 1 (pc %h)", FetchGnt, addr);
    end else if (push_exp) begin
      exp_instr_q.push_back(model_mem[widx(addr)]);
    end
    @(posedge clk); #1;
    FetchReq = 1'b0;
  endtask

  task automatic test_reset();
    FetchReq = 1'b1; Op2En = 1'b1; Op2RW = 1'b0;
    @(negedge clk);
    checks++;
    if ({FetchGnt, Op2Gnt} !== 2'b00) begin
      errors++;
      $display("FAIL reset_grants: got %b required 00", {FetchGnt, Op2Gnt});
    end
    checks++;
    if ({Instruction, DataRead, InstrValid, DataValid, FetchFault, DataFault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: Instr=%h Data=%h IV=%b DV=%b FF=%b DF=%b required all 0",
               Instruction, DataRead, InstrValid, DataValid, FetchFault, DataFault);
    end
    @(posedge clk); #1;
    FetchReq = 1'b0; Op2En = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    data_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    data_op(1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (!DataValid || DataRead !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read: DV=%b DataRead=%h required 1 deadbeef", DataValid, DataRead);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_en();
    data_op(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    data_op(1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (!DataValid || DataRead !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL byte_en: DV=%b DataRead=%h required 1 deadbeaa", DataValid, DataRead);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    logic [5:0] exp_dgnt;
    exp_dgnt = 6'b101111;
    FetchReq = 1'b1; ReadPC = 32'h10;
    Op2En = 1'b1; Op2RW = 1'b0; ReadWriteAddr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({FetchGnt, Op2Gnt} !== {!exp_dgnt[i], exp_dgnt[i]}) begin
        errors++;
        $display("FAIL arbitration_cycle%0d: FetchGnt/Op2Gnt=%b required %b",
                 i + 1, {FetchGnt, Op2Gnt}, {!exp_dgnt[i], exp_dgnt[i]});
      end
      if (exp_dgnt[i]) exp_data_q.push_back(32'hDEADBEAA);
      else             exp_instr_q.push_back(32'hDEADBEAA);
      @(posedge clk); #1;
    end
    FetchReq = 1'b0; Op2En = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    data_op(1'b1, 32'h0, 32'h00000001, 4'hF);
    fetch_op(32'h1000, 1'b1);
    @(negedge clk);
    checks++;
    if (!InstrValid || Instruction !== 32'h00000001) begin
      errors++;
      $display("FAIL fetch_wrap: IV=%b Instruction=%h required 1 00000001", InstrValid, Instruction);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_CHECK_EN
    fetch_op(32'h2, 1'b0);
    @(negedge clk);
    checks++;
    if (FetchFault !== 1'b1 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_misalign: FetchFault=%b InstrValid=%b required 1 0", FetchFault, InstrValid);
    end
`else
    fetch_op(32'h2, 1'b1);
    @(negedge clk);
    checks++;
    if (FetchFault !== 1'b0 || InstrValid !== 1'b1 || Instruction !== 32'h00000001) begin
      errors++;
      $display("FAIL fetch_misalign: FF=%b IV=%b Instruction=%h required 0 1 00000001",
               FetchFault, InstrValid, Instruction);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) data_op(1'b1, 32'h200 + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] be;
      be = (i == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      data_op(1'b1, 32'h200 + 32'(4 * i), $urandom, be);
      data_op(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0);
    end
    fetch_op(32'h204, 1'b1);
    for (int i = 0; i < 8; i++) data_op(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_data_q.size() != 0 || exp_instr_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain: pending data=%0d instr=%0d required 0 0",
               exp_data_q.size(), exp_instr_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    data_op(1'b1, 32'h40, 32'h12345678, 4'hF);
    Op2En = 1'b1; Op2RW = 1'b0; ReadWriteAddr = 32'h40;
    @(negedge clk);
    checks++;
    if (Op2Gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_grant: Op2Gnt=%b required 1", Op2Gnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    FetchReq = 1'b1;
    @(negedge clk);
    checks++;
    if ({DataValid, DataRead, InstrValid, Instruction} !== '0) begin
      errors++;
      $display("FAIL reset_mid_read: DV=%b DataRead=%h IV=%b Instr=%h required all 0",
               DataValid, DataRead, InstrValid, Instruction);
    end
    checks++;
    if ({FetchGnt, Op2Gnt} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_grants: got %b required 00", {FetchGnt, Op2Gnt});
    end
    @(posedge clk); #1;
    reset = 1'b0; FetchReq = 1'b0; Op2En = 1'b0;
    @(posedge clk); #1;
    data_op(1'b0, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (!DataValid || DataRead !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_array_kept: DV=%b DataRead=%h required 1 12345678", DataValid, DataRead);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_en();
    test_arbitration();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_reset_mid_read();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_data_q.size() != 0 || exp_instr_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: pending data=%0d instr=%0d required 0 0",
               exp_data_q.size(), exp_instr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
